// File: rtl/if_inst_queue_pkg.sv
// IF->ID instruction queue shared constants and beat layout.
// Depth lives here so the top level and the bench agree on one value.
package if_inst_queue_pkg;

  localparam int BUS_WD   = 66;
  localparam int IQ_DEPTH = 2;
  localparam int PTR_WD   = $clog2(IQ_DEPTH);

  localparam logic [PTR_WD:0] FULL_CNT =
    (PTR_WD+1)'(IQ_DEPTH);

  typedef struct packed {
    logic        bd;
    logic        ex;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

endpackage

// File: rtl/if_inst_queue.sv
// Decoupling FIFO between IF and ID; holds fetched beats across ID stalls.
// Registered output, no bypass; flushed with IF/ID on WB exception or eret.
module if_inst_queue
  import if_inst_queue_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              fs_to_iq_valid,
  input  logic [BUS_WD-1:0] fs_to_iq_bus,
  output logic              iq_allowin,
  input  logic              ds_allowin,
  output logic              iq_to_ds_valid,
  output logic [BUS_WD-1:0] iq_to_ds_bus,
  input  logic              ex_from_ws,
  output logic [PTR_WD:0]   iq_count
);

  logic [BUS_WD-1:0] mem_q [IQ_DEPTH];
  logic [BUS_WD-1:0] mem_d [IQ_DEPTH];
  logic [PTR_WD-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WD-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WD:0]   count_q, count_d;
  logic              push, pop;

  // Full queue still accepts when the head leaves this cycle.
  assign iq_allowin     = (count_q != FULL_CNT) || ds_allowin;
  assign iq_to_ds_valid = (count_q != '0);
  assign iq_to_ds_bus   = mem_q[rd_ptr_q];
  assign iq_count       = count_q;

  assign push = fs_to_iq_valid && iq_allowin;
  assign pop  = iq_to_ds_valid && ds_allowin;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (ex_from_ws) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = fs_to_iq_bus;
        wr_ptr_d        = wr_ptr_q + PTR_WD'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_WD'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + (PTR_WD+1)'(1);
        2'b01:   count_d = count_q - (PTR_WD+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_if_inst_queue.sv
// Self-checking bench for if_inst_queue: directed cases then random traffic.
// Reference is a queue of beats plus an occupancy count.
module tb_if_inst_queue;
  import if_inst_queue_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              fs_to_iq_valid;
  logic [BUS_WD-1:0] fs_to_iq_bus;
  logic              iq_allowin;
  logic              ds_allowin;
  logic              iq_to_ds_valid;
  logic [BUS_WD-1:0] iq_to_ds_bus;
  logic              ex_from_ws;
  logic [PTR_WD:0]   iq_count;

  if_inst_queue dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_iq_valid (fs_to_iq_valid),
    .fs_to_iq_bus   (fs_to_iq_bus),
    .iq_allowin     (iq_allowin),
    .ds_allowin     (ds_allowin),
    .iq_to_ds_valid (iq_to_ds_valid),
    .iq_to_ds_bus   (iq_to_ds_bus),
    .ex_from_ws     (ex_from_ws),
    .iq_count       (iq_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [BUS_WD-1:0] sb[$];
  int  m_count = 0;
  bit  known   = 0;

  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [BUS_WD-1:0] beat(
    logic bd, logic ex, logic [31:0] inst, logic [31:0] pc);
    fs_to_ds_t b;
    b.bd = bd; b.ex = ex; b.inst = inst; b.pc = pc;
    return b;
  endfunction

  // Inputs at negedge; levels checked at +1; monitor at +2; model update at +3.
  task automatic cycle(bit rst, bit v, logic [BUS_WD-1:0] bus,
                       bit dsa, bit ex, output bit pushed);
    bit exp_allow;
    @(negedge clk);
    reset          = rst;
    fs_to_iq_valid = v;
    fs_to_iq_bus   = bus;
    ds_allowin     = dsa;
    ex_from_ws     = ex;
    #1;
    exp_allow = (m_count != IQ_DEPTH) || dsa;
    pushed    = v && exp_allow;
    if (known) begin
      check("iq_count", 128'(iq_count), 128'(m_count));
      check("iq_to_ds_valid", 128'(iq_to_ds_valid), 128'(m_count != 0));
      check("iq_allowin", 128'(iq_allowin), 128'(exp_allow));
    end
    #2;
    if (rst) begin
      sb.delete();
      m_count = 0;
      known   = 1;
    end else if (known) begin
      if (ex) begin
        sb.delete();
        m_count = 0;
      end else begin
        if (pushed) sb.push_back(bus);
        m_count = sb.size();
      end
    end
  endtask

  // Monitor: compares presented head with scoreboard and retires popped beats.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (known && !reset && sb.size() != 0) begin
        check("iq_to_ds_bus", 128'(iq_to_ds_bus), 128'(sb[0]));
        if (ds_allowin && !ex_from_ws) void'(sb.pop_front());
      end
    end
  end

  localparam logic [31:0] PC0 = 32'hbfc00000;

  initial begin
    bit p;
    logic [BUS_WD-1:0] b;
    reset = 1'b1; fs_to_iq_valid = 0; fs_to_iq_bus = '0;
    ds_allowin = 0; ex_from_ws = 0;

    repeat (3) cycle(1, 0, '0, 0, 0, p);
    cycle(0, 0, '0, 1, 0, p);

    for (int i = 0; i < 3; i++)
      cycle(0, 1, beat(0, 0, 32'h1000 + i, PC0 + 4*i), 1, 0, p);
    cycle(0, 0, '0, 1, 0, p);
    cycle(0, 0, '0, 1, 0, p);

    cycle(0, 1, beat(0, 0, 32'h11, PC0), 0, 0, p);
    cycle(0, 1, beat(0, 0, 32'h22, PC0 + 4), 0, 0, p);
    b = beat(0, 0, 32'h33, PC0 + 8);
    p = 0;
    for (int k = 0; k < 4 && !p; k++)
      cycle(0, 1, b, k == 3, 0, p);
    if (!p) begin
      n_chk++; n_fail++;
      $display("FAIL held_beat: got not-accepted expected accepted");
    end
    cycle(0, 0, '0, 1, 0, p);
    cycle(0, 0, '0, 1, 0, p);
    cycle(0, 0, '0, 1, 0, p);

    cycle(0, 1, beat(0, 0, 32'h44, PC0), 0, 0, p);
    cycle(0, 1, beat(0, 0, 32'h55, PC0 + 4), 0, 0, p);
    cycle(0, 1, beat(0, 0, 32'h66, PC0 + 8), 1, 0, p);
    cycle(0, 0, '0, 0, 0, p);
    cycle(0, 1, beat(0, 0, 32'h77, PC0 + 12), 1, 1, p);
    cycle(0, 0, '0, 0, 0, p);
    cycle(0, 1, beat(0, 0, 32'h88, PC0 + 32'h380), 0, 0, p);
    cycle(0, 0, '0, 1, 0, p);
    cycle(0, 0, '0, 1, 0, p);

    cycle(0, 1, beat(1, 1, 32'hdeadbeef, 32'hbfc00001), 0, 0, p);
    cycle(0, 0, '0, 1, 0, p);
    cycle(0, 0, '0, 1, 0, p);

    cycle(0, 1, beat(0, 0, 32'h99, PC0), 0, 0, p);
    cycle(1, 1, beat(0, 0, 32'haa, PC0 + 4), 1, 0, p);
    cycle(0, 0, '0, 1, 0, p);

    for (int i = 0; i < 400; i++) begin
      b = {2'($urandom), $urandom, $urandom};
      cycle($urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 70, b,
            $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 5, p);
    end
    cycle(0, 0, '0, 1, 0, p);
    cycle(0, 0, '0, 1, 0, p);
    cycle(0, 0, '0, 1, 0, p);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
